midi_event_scheduler: RTL and testbench
=======================================

Name: midi_event_scheduler

Overview:
- Timestamped MIDI event queue downstream of the board millisecond timer.
- Consumes the free-running 16-bit millisecond count and holds up to DEPTH pending events written by the parser/sequencer.
- Releases each event on a valid/ready output when the current time reaches its timestamp; the output feeds the note/voice allocator.
- Ordering is by insertion. The writer guarantees non-decreasing timestamps.

Parameters:
- DEPTH, 8: number of queued events; power of two, minimum 2.
- DATA_W, 24: event payload width (status, note, velocity bytes).
- LATE_MS, 16'd20: an event released more than this many ms after its timestamp is flagged late.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- now_time  input  16  current millisecond count from the timer; increments by 1, wraps 0xFFFF->0x0000
- flush  input  1  synchronous clear of queue and output
- wr_valid  input  1  write request
- wr_ready  output  1  queue can accept (not full)
- wr_time  input  16  event timestamp in ms
- wr_data  input  DATA_W  event payload
- ev_valid  output  1  due event presented
- ev_ready  input  1  consumer accepts event
- ev_data  output  DATA_W  payload of presented event
- ev_late  output  1  presented event exceeded LATE_MS
- count  output  $clog2(DEPTH)+1  number of stored entries, including one being presented

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all pointers 0, count=0, state IDLE, ev_valid=0, ev_data=0, ev_late=0, wr_ready=1. Storage contents are don't-care.
- Storage: circular buffer with wr_ptr, rd_ptr and count.
  - Write accepted on a clock edge with wr_valid && wr_ready.
  - wr_ready = (count != DEPTH), combinational from registered count.
  - A write while full is ignored, with no state change.
- Due test (wrap-safe):
  - diff = now_time - head_time, computed modulo 2^16.
  - The head is due when diff[15]==0, i.e. the timestamp is up to 32767 ms in the past or equal to now.
  - Late when due and diff > LATE_MS.
- State machine:
  - IDLE: count==0. Go to WAIT when count becomes nonzero.
  - WAIT: head stored, not presented. If the head is due this cycle, go to FIRE next cycle: ev_valid<=1, ev_data<=head data, ev_late<=late result. Otherwise stay.
  - FIRE: ev_valid, ev_data and ev_late are held stable until ev_ready is sampled high. On acceptance:
    - pop the head (rd_ptr+1, count-1);
    - ev_valid<=0;
    - next state is WAIT if the remaining count is >0, else IDLE.
- Latency and spacing:
  - Minimum latency from "head due" (or "write into empty queue with past timestamp") to ev_valid is 1 cycle after the entry is visible as head.
  - A written entry is visible as head the cycle after the write edge.
  - Back-to-back due events are spaced by at least one ev_valid-low cycle.
- Simultaneous write and pop in one cycle: both take effect and count is unchanged. Writing while full in the same cycle as a pop is not accepted, because wr_ready is computed from pre-pop count.
- flush: takes priority over write and pop. The next state equals the reset state; any presented event is dropped. rst has priority over flush.
- Reset mid-FIRE: ev_valid drops asynchronously and the event is lost.
- Pointer wrap-around: modulo DEPTH, with no gap at the boundary.
- now_time may jump (e.g. timer reset). Due evaluation is purely combinational from current now_time; no history is kept.

Test Plan:
- Timing: reset, now_time=100; write (t=105, data=0x903C40); hold ev_ready=1 -> ev_valid first high in the cycle after now_time reaches 105; ev_data=0x903C40, ev_late=0, count 1->0.
- Past timestamp and late flag: now_time=200; write t=150 -> ev_valid 2 cycles after the write edge, ev_late=1 (diff=50>20). Write t=190 -> ev_late=0 (diff=10).
- Wrap-around: now_time=0xFFFE; write t=0x0002 -> not released at 0xFFFE/0xFFFF, released at 0x0002. Write t=0xFFF0 at now_time=0x0005 -> immediate release, ev_late=1.
- Full/backpressure: ev_ready=0, timestamps in the future, write 9 events -> wr_ready=0 after the 8th write, the 9th is ignored, count=8. Advance time and assert ev_ready -> 8 events out in write order with one-cycle gaps between ev_valid pulses.
- Handshake stability and simultaneous write+pop: hold ev_ready=0 for 5 cycles with ev_valid=1 -> ev_data is stable. Then assert ev_ready in the same cycle as a write with count=3 -> count stays 3.
- Flush and reset: flush during FIRE with count=4 -> next cycle count=0, ev_valid=0, wr_ready=1. Assert rst asynchronously mid-FIRE -> ev_valid=0 immediately; after release the queue is empty and state is IDLE.

Source files
------------

// File: rtl/midi_event_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module     : midi_event_scheduler_if
// Description: Timer, write-port and event-port bundle of the MIDI scheduler.
// Revision   : 1.0 - initial release
// ============================================================================
interface midi_event_scheduler_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 24
);
    logic [15:0]              now_time;
    logic                     flush;
    logic                     wr_valid;
    logic                     wr_ready;
    logic [15:0]              wr_time;
    logic [DATA_W-1:0]        wr_data;
    logic                     ev_valid;
    logic                     ev_ready;
    logic [DATA_W-1:0]        ev_data;
    logic                     ev_late;
    logic [$clog2(DEPTH):0]   count;

    modport slave (
        input  now_time, flush, wr_valid, wr_time, wr_data, ev_ready,
        output wr_ready, ev_valid, ev_data, ev_late, count
    );

    modport master (
        output now_time, flush, wr_valid, wr_time, wr_data, ev_ready,
        input  wr_ready, ev_valid, ev_data, ev_late, count
    );
endinterface
`default_nettype wire

// File: rtl/midi_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : midi_event_scheduler
// Description: Insertion-ordered timestamped event queue; releases the head
//              when the millisecond timer reaches its timestamp.
// Revision   : 1.0 - initial release
// ============================================================================
module midi_event_scheduler #(
    parameter int          DEPTH   = 8,
    parameter int          DATA_W  = 24,
    parameter logic [15:0] LATE_MS = 16'd20
) (
    input  wire logic             clk,
    input  wire logic             rst,
    midi_event_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIRE = 2'd2
    } state_t;

    logic [15:0]       time_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    state_t            state_q,    state_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic              ev_valid_q, ev_valid_d;
    logic              ev_late_q,  ev_late_d;
    logic [DATA_W-1:0] ev_data_q,  ev_data_d;

    logic              wr_ready;
    logic              wr_fire;
    logic              pop;
    logic [15:0]       diff;
    logic              head_due;
    logic              head_late;

    assign wr_ready  = (count_q != CNT_W'(DEPTH));
    assign wr_fire   = bus.wr_valid && wr_ready && !bus.flush;
    assign pop       = (state_q == FIRE) && bus.ev_ready;

    // Modulo-2^16 difference: anything up to half the range behind now is due.
    assign diff      = bus.now_time - time_mem[rd_ptr_q];
    assign head_due  = !diff[15];
    assign head_late = head_due && (diff > LATE_MS);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ev_valid_d = ev_valid_q;
        ev_late_d  = ev_late_q;
        ev_data_d  = ev_data_q;

        if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({wr_fire, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: if (count_q != '0) state_d = WAIT;
            WAIT: begin
                if (head_due) begin
                    state_d    = FIRE;
                    ev_valid_d = 1'b1;
                    ev_data_d  = data_mem[rd_ptr_q];
                    ev_late_d  = head_late;
                end
            end
            FIRE: begin
                if (bus.ev_ready) begin
                    ev_valid_d = 1'b0;
                    state_d    = (count_d != '0) ? WAIT : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush) begin
            state_d    = IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ev_valid_d = 1'b0;
            ev_late_d  = 1'b0;
            ev_data_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ev_valid_q <= 1'b0;
            ev_late_q  <= 1'b0;
            ev_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ev_valid_q <= ev_valid_d;
            ev_late_q  <= ev_late_d;
            ev_data_q  <= ev_data_d;
        end
    end

    // Payload storage carries no reset; only entries behind the pointers are read.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            time_mem[wr_ptr_q] <= bus.wr_time;
            data_mem[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.ev_valid = ev_valid_q;
    assign bus.ev_data  = ev_data_q;
    assign bus.ev_late  = ev_late_q;
    assign bus.count    = count_q;
endmodule
`default_nettype wire

// File: tb/tb_midi_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : tb_midi_event_scheduler
// Description: Directed self-checking bench for midi_event_scheduler.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_midi_event_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    midi_event_scheduler_if #(.DEPTH(8), .DATA_W(24)) bus ();

    midi_event_scheduler #(
        .DEPTH   (8),
        .DATA_W  (24),
        .LATE_MS (16'd20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step_hold();
        @(posedge clk);
        #1;
    endtask

    task automatic step_adv();
        @(posedge clk);
        #1;
        bus.now_time = bus.now_time + 16'd1;
    endtask

    task automatic write_ev(input logic [15:0] t, input logic [23:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_time  = t;
        bus.wr_data  = d;
        step_hold();
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit adv, input string tag);
        int n = 0;
        while (bus.ev_valid !== 1'b1 && n < 40) begin
            if (adv) step_adv();
            else     step_hold();
            n++;
        end
        chk(tag, {31'd0, bus.ev_valid}, 32'd1);
    endtask

    initial begin
        int k;
        logic prev;

        bus.now_time = 16'd100;
        bus.flush    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_time  = 16'd0;
        bus.wr_data  = 24'd0;
        bus.ev_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", {31'd0, bus.ev_valid}, 32'd0);
        chk("rst_count", {28'd0, bus.count}, 32'd0);
        chk("rst_wready", {31'd0, bus.wr_ready}, 32'd1);
        chk("rst_data", {8'd0, bus.ev_data}, 32'd0);
        chk("rst_late", {31'd0, bus.ev_late}, 32'd0);

        // Future timestamp: released the cycle after now reaches 105
        bus.ev_ready = 1'b1;
        write_ev(16'd105, 24'h903C40);
        chk("t1_count1", {28'd0, bus.count}, 32'd1);
        wait_valid(1'b1, "t1_release");
        chk("t1_now", {16'd0, bus.now_time}, 32'd106);
        chk("t1_data", {8'd0, bus.ev_data}, 32'h903C40);
        chk("t1_late", {31'd0, bus.ev_late}, 32'd0);
        step_hold();
        chk("t1_count0", {28'd0, bus.count}, 32'd0);
        chk("t1_drop", {31'd0, bus.ev_valid}, 32'd0);

        // Past timestamps: two cycles after the write edge
        bus.now_time = 16'd200;
        write_ev(16'd150, 24'h111111);
        chk("t2a_e0", {31'd0, bus.ev_valid}, 32'd0);
        step_hold();
        chk("t2a_e1", {31'd0, bus.ev_valid}, 32'd0);
        step_hold();
        chk("t2a_e2", {31'd0, bus.ev_valid}, 32'd1);
        chk("t2a_late", {31'd0, bus.ev_late}, 32'd1);
        chk("t2a_data", {8'd0, bus.ev_data}, 32'h111111);
        step_hold();
        write_ev(16'd190, 24'h222222);
        step_hold();
        step_hold();
        chk("t2b_valid", {31'd0, bus.ev_valid}, 32'd1);
        chk("t2b_late", {31'd0, bus.ev_late}, 32'd0);
        step_hold();

        // Timer wrap: t=2 written at FFFE, released once now reaches 2
        bus.now_time = 16'hFFFE;
        write_ev(16'h0002, 24'h333333);
        wait_valid(1'b1, "t3a_release");
        chk("t3a_now", {16'd0, bus.now_time}, 32'd3);
        chk("t3a_data", {8'd0, bus.ev_data}, 32'h333333);
        step_hold();
        bus.now_time = 16'h0005;
        write_ev(16'hFFF0, 24'h444444);
        step_hold();
        step_hold();
        chk("t3b_valid", {31'd0, bus.ev_valid}, 32'd1);
        chk("t3b_late", {31'd0, bus.ev_late}, 32'd1);
        step_hold();
        chk("t3b_count", {28'd0, bus.count}, 32'd0);

        // Fill to capacity under backpressure, then drain in order
        bus.ev_ready = 1'b0;
        bus.now_time = 16'h1000;
        for (int i = 0; i < 8; i++) write_ev(16'h2000 + 16'(i), 24'hA00000 + 24'(i));
        chk("t4_full_count", {28'd0, bus.count}, 32'd8);
        chk("t4_full_wready", {31'd0, bus.wr_ready}, 32'd0);
        write_ev(16'h2008, 24'hA00008);
        chk("t4_ninth", {28'd0, bus.count}, 32'd8);
        chk("t4_hold", {31'd0, bus.ev_valid}, 32'd0);
        bus.now_time = 16'h3000;
        bus.ev_ready = 1'b1;
        k    = 0;
        prev = 1'b0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            step_hold();
            if (bus.ev_valid === 1'b1) begin
                chk("t4_order", {8'd0, bus.ev_data}, 32'hA00000 + 32'(k));
                chk("t4_gap", {31'd0, prev}, 32'd0);
                k++;
            end
            prev = bus.ev_valid;
        end
        chk("t4_drained", k, 32'd8);
        step_hold();
        chk("t4_empty", {28'd0, bus.count}, 32'd0);
        step_hold();
        step_hold();
        chk("t4_no_ninth", {31'd0, bus.ev_valid}, 32'd0);

        // Held event stays stable; then write and pop in the same cycle
        bus.ev_ready = 1'b0;
        bus.now_time = 16'h4000;
        for (int i = 0; i < 3; i++) write_ev(16'h3FF0 + 16'(i), 24'hB00000 + 24'(i));
        wait_valid(1'b0, "t5_present");
        chk("t5_count", {28'd0, bus.count}, 32'd3);
        chk("t5_late", {31'd0, bus.ev_late}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step_hold();
            chk("t5_stable_v", {31'd0, bus.ev_valid}, 32'd1);
            chk("t5_stable_d", {8'd0, bus.ev_data}, 32'hB00000);
        end
        bus.ev_ready = 1'b1;
        write_ev(16'h4000, 24'hB00003);
        bus.ev_ready = 1'b0;
        chk("t5_wrpop_count", {28'd0, bus.count}, 32'd3);
        chk("t5_wrpop_valid", {31'd0, bus.ev_valid}, 32'd0);

        // Flush while presenting with four stored
        write_ev(16'h4000, 24'hB00004);
        wait_valid(1'b0, "t6_present");
        chk("t6_count4", {28'd0, bus.count}, 32'd4);
        chk("t6_head", {8'd0, bus.ev_data}, 32'hB00001);
        bus.flush = 1'b1;
        step_hold();
        bus.flush = 1'b0;
        chk("t6_fl_count", {28'd0, bus.count}, 32'd0);
        chk("t6_fl_valid", {31'd0, bus.ev_valid}, 32'd0);
        chk("t6_fl_wready", {31'd0, bus.wr_ready}, 32'd1);
        step_hold();
        step_hold();
        chk("t6_fl_quiet", {31'd0, bus.ev_valid}, 32'd0);

        // Asynchronous reset in the middle of a presented event
        write_ev(16'h4000, 24'hCCCCCC);
        wait_valid(1'b0, "t7_present");
        #2;
        rst = 1'b1;
        #1;
        chk("t7_async_valid", {31'd0, bus.ev_valid}, 32'd0);
        chk("t7_async_count", {28'd0, bus.count}, 32'd0);
        step_hold();
        rst = 1'b0;
        step_hold();
        chk("t7_post_valid", {31'd0, bus.ev_valid}, 32'd0);
        chk("t7_post_wready", {31'd0, bus.wr_ready}, 32'd1);
        write_ev(16'h4000, 24'hDDDDDD);
        chk("t7_idle_e0", {31'd0, bus.ev_valid}, 32'd0);
        step_hold();
        chk("t7_idle_e1", {31'd0, bus.ev_valid}, 32'd0);
        step_hold();
        chk("t7_idle_e2", {31'd0, bus.ev_valid}, 32'd1);
        chk("t7_idle_data", {8'd0, bus.ev_data}, 32'hDDDDDD);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
